// File: rtl/uart_lb_pkg.sv
// Shared definitions for the UART <-> local-bus host-link bridge:
// sync marker words, command-word field widths and the Rx/Tx FSM state types.
package uart_lb_pkg;

  localparam int CMDW  = 8;
  localparam int ADDRW = 24;
  localparam int DATAW = 32;
  localparam int WORDW = CMDW + ADDRW + DATAW;

  localparam logic [WORDW-1:0] SYNC0 = 64'hffffffffffffffff;
  localparam logic [WORDW-1:0] SYNC1 = 64'hffffffffffffff00;

  typedef enum logic {
    HUNT,
    SYNCED
  } rx_state_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    BUSY,
    DRAIN
  } tx_state_e;

  // Sync marker words arriving on an aligned stream carry no command.
  function automatic logic is_sync_word(input logic [WORDW-1:0] w);
    return (w == SYNC0) || (w == SYNC1);
  endfunction

endpackage

// File: rtl/uart_lb_txser.sv
// Read-return serializer: accepts one 64-bit word when idle and sends it to
// the UART transmitter MSB byte first, one byte per txready idle period.
module uart_lb_txser
  import uart_lb_pkg::*;
(
  input  logic             clk,
  input  logic             rstn,
  input  logic [WORDW-1:0] rdata,
  input  logic             rvalid,
  output logic             rready,
  output logic [7:0]       txdata,
  output logic             txstart,
  input  logic             txready
);

  tx_state_e        state_q, state_d;
  logic [WORDW-1:0] sh_q, sh_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       txdata_q, txdata_d;
  logic             txstart_q, txstart_d;
  logic             rready_q, rready_d;

  // Next-state: handshake in IDLE, one start strobe per byte, then wait for
  // the transmitter to go busy and return to idle before the next byte.
  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    idx_d     = idx_q;
    txdata_d  = txdata_q;
    txstart_d = 1'b0;
    case (state_q)
      IDLE: begin
        // rready_q guards the first cycle after reset, when rready is still 0.
        if (rvalid && rready_q) begin
          sh_d    = rdata;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (txready) begin
          txdata_d  = sh_q[WORDW-1 -: 8];
          txstart_d = 1'b1;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        if (!txready) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (txready) begin
          sh_d    = {sh_q[WORDW-9:0], 8'h00};
          idx_d   = idx_q + 3'd1;
          state_d = (idx_q == 3'd7) ? IDLE : SEND;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that rready reads 0 throughout reset and 1 once running.
    rready_d = (state_d == IDLE);
  end

  // State and datapath registers; reset returns to an idle, silent transmitter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      idx_q     <= '0;
      txdata_q  <= '0;
      txstart_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      idx_q     <= idx_d;
      txdata_q  <= txdata_d;
      txstart_q <= txstart_d;
      rready_q  <= rready_d;
    end
  end

  assign rready  = rready_q;
  assign txdata  = txdata_q;
  assign txstart = txstart_q;

endmodule

// File: rtl/uart_lb_bridge.sv
// UART byte stream <-> 64-bit local-bus command bridge.
// Rx: hunts for the {SYNC0, SYNC1} marker, then assembles big-endian
// {cmd, addr, data} words and strobes them out on wcmd/wvalid, dropping
// any in-stream sync words. Tx: read-return words go to uart_lb_txser.
// Optional inter-byte gap timer: define UART_LB_BRIDGE_TIMEOUT_EN.
module uart_lb_bridge
  import uart_lb_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TOCNTW  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [7:0]        rxdata,
  input  logic              rxvalid,
  output logic [7:0]        txdata,
  output logic              txstart,
  input  logic              txready,
  output logic [WORDW-1:0]  wcmd,
  output logic              wvalid,
  input  logic [WORDW-1:0]  rdata,
  input  logic              rvalid,
  output logic              rready,
  output logic              synced,
  output logic [TOCNTW-1:0] tocnt
);

  localparam logic [2*WORDW-1:0] SYNC_MARK = {SYNC0, SYNC1};

  rx_state_e          rx_state_q, rx_state_d;
  logic [2*WORDW-1:0] hist_q, hist_d;
  logic [WORDW-1:0]   asm_q, asm_d;
  logic [WORDW-1:0]   asm_shift;
  logic [WORDW-1:0]   wcmd_q, wcmd_d;
  logic               wvalid_q, wvalid_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               to_abort;

  assign asm_shift = {asm_q[WORDW-9:0], rxdata};

  // Rx next-state: marker hunting, byte assembly and gap-timeout abort.
  always_comb begin
    rx_state_d = rx_state_q;
    hist_d     = hist_q;
    asm_d      = asm_q;
    cnt_d      = cnt_q;
    wcmd_d     = wcmd_q;
    wvalid_d   = 1'b0;
    if (rxvalid) begin
      case (rx_state_q)
        HUNT: begin
          if (hist_q == SYNC_MARK) begin
            // History still holds the marker (e.g. after a timeout):
            // this byte already starts the next aligned word.
            rx_state_d = SYNCED;
            asm_d      = asm_shift;
            cnt_d      = 3'd1;
          end else begin
            hist_d = {hist_q[2*WORDW-9:0], rxdata};
            if (hist_d == SYNC_MARK) begin
              rx_state_d = SYNCED;
              cnt_d      = 3'd0;
            end
          end
        end
        SYNCED: begin
          asm_d = asm_shift;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7 && !is_sync_word(asm_shift)) begin
            wcmd_d   = asm_shift;
            wvalid_d = 1'b1;
          end
        end
        default: rx_state_d = HUNT;
      endcase
    end else if (to_abort) begin
      rx_state_d = HUNT;
      asm_d      = '0;
      cnt_d      = 3'd0;
    end
  end

  // Rx registers; a reset drops any partial word and alignment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state_q <= HUNT;
      hist_q     <= '0;
      asm_q      <= '0;
      cnt_q      <= '0;
      wcmd_q     <= '0;
      wvalid_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      hist_q     <= hist_d;
      asm_q      <= asm_d;
      cnt_q      <= cnt_d;
      wcmd_q     <= wcmd_d;
      wvalid_q   <= wvalid_d;
    end
  end

`ifdef UART_LB_BRIDGE_TIMEOUT_EN
  localparam int GAPW = $clog2(TIMEOUT + 1);

  logic [GAPW-1:0]   gap_q, gap_d;
  logic [TOCNTW-1:0] tocnt_q, tocnt_d;

  // Gap timer: runs only inside a partial aligned word; a received byte
  // always clears it, so a byte landing on the expiry cycle wins.
  always_comb begin
    gap_d    = '0;
    tocnt_d  = tocnt_q;
    to_abort = 1'b0;
    if (!rxvalid && rx_state_q == SYNCED && cnt_q != 3'd0) begin
      if (gap_q == GAPW'(TIMEOUT - 1)) begin
        to_abort = 1'b1;
        if (tocnt_q != '1) begin
          tocnt_d = tocnt_q + TOCNTW'(1);
        end
      end else begin
        gap_d = gap_q + GAPW'(1);
      end
    end
  end

  // Gap counter and saturating abort counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      gap_q   <= '0;
      tocnt_q <= '0;
    end else begin
      gap_q   <= gap_d;
      tocnt_q <= tocnt_d;
    end
  end

  assign tocnt = tocnt_q;
`else
  // TIMEOUT only matters when the gap timer is built.
  localparam int unused_timeout = TIMEOUT;

  assign to_abort = 1'b0;
  assign tocnt    = '0;
`endif

  assign synced = (rx_state_q == SYNCED);
  assign wcmd   = wcmd_q;
  assign wvalid = wvalid_q;

  uart_lb_txser u_txser (
    .clk     (clk),
    .rstn    (rstn),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .rready  (rready),
    .txdata  (txdata),
    .txstart (txstart),
    .txready (txready)
  );

endmodule

// File: doc/uart_lb_bridge.md
# uart_lb_bridge

Host-link bridge between the 8-bit UART byte interface (`uart` rxdata/rxvalid, txdata/txstart/txready) and the 64-bit local-bus command port (`lb.wcmd`/`lb.wvalid`, read data return). It hunts for the two-word sync marker, assembles big-endian 64-bit `{cmd[7:0], addr[23:0], data[31:0]}` words and issues them as local-bus commands. In the reverse direction it serializes 64-bit read-return words into UART bytes, MSB first. It sits in `qubichw_config` between the UART and the `lbreg` command path.

## Interface
- `TIMEOUT`, 1000: max clk cycles between consecutive rx bytes inside a partial word.
- `TOCNTW`, 16: width of the timeout counter and the `tocnt` status output.

- `clk`  in  1  UART clock domain; all logic on posedge.
- `rstn`  in  1  asynchronous, active-low reset.
- `rxdata`  in  8  received byte.
- `rxvalid`  in  1  one-cycle strobe; `rxdata` valid.
- `txdata`  out  8  byte to transmit.
- `txstart`  out  1  one-cycle transmit strobe.
- `txready`  in  1  UART transmitter idle.
- `wcmd`  out  64  assembled command word.
- `wvalid`  out  1  one-cycle strobe; `wcmd` valid.
- `rdata`  in  64  read-return word.
- `rvalid`  in  1  `rdata` offered.
- `rready`  out  1  bridge can accept `rdata`.
- `synced`  out  1  word alignment established.
- `tocnt`  out  TOCNTW  saturating count of timeout aborts.

## Operation
- Constants: SYNC0 = 64'hffffffffffffffff, SYNC1 = 64'hffffffffffffff00.
- Rx FSM states:
  - HUNT: shift every rx byte into a 128-bit history register. When history == {SYNC0, SYNC1} → SYNCED, byte count 0.
  - SYNCED: shift bytes into a 64-bit assembly register, MSB first; byte count 0..7.
    - On the 8th byte: if the word is SYNC0 or SYNC1, discard it silently. Otherwise load `wcmd` and pulse `wvalid`.
    - Byte count wraps to 0 in both cases.
- `wcmd` holds its value until the next emitted word.
- Gap timer (macro-gated, see Configuration):
  - Clears on each rxvalid. Runs only in SYNCED with byte count ≠ 0.
  - On reaching TIMEOUT: discard the partial word, byte count 0, increment `tocnt` (saturating), → HUNT.
- Tx FSM states:
  - IDLE: `rready`=1. On rvalid: latch `rdata` into the shift register, byte index 0 → SEND.
  - SEND: when `txready`=1, drive `txdata` = top byte and pulse `txstart` for one cycle → BUSY.
  - BUSY: wait for `txready`=0 → DRAIN.
  - DRAIN: wait for `txready`=1. Then shift left 8 and increment the index. After index 7 → IDLE, else → SEND.
  - `rready`=1 only in IDLE.
- Rx and Tx paths are independent and operate concurrently.

## Timing
- Reset values:
  - Outputs: `txdata`=0, `txstart`=0, `wcmd`=0, `wvalid`=0, `rready`=0 while `rstn` low and 1 afterwards, `synced`=0, `tocnt`=0.
  - FSMs: Rx=HUNT, Tx=IDLE.
  - History and assembly registers are cleared.
- Rx latency: `wvalid` is high in the cycle after the rxvalid of the 8th byte.
- `synced` is high in the cycle after the rxvalid that completes SYNC1, and falls in the cycle after a timeout.
- Tx: first `txstart` no earlier than 1 cycle after the rvalid&rready handshake. 8 `txstart` pulses per word. Never two pulses without an intervening `txready` low→high.
- rvalid while `rready`=0: not accepted; the source must hold `rdata`/`rvalid`.
- Timeout and rxvalid in the same cycle: the rxvalid wins; the byte is accepted and the timer clears.
- `rstn` asserted mid-word or mid-transmit: immediate return to reset state. The partial word is lost, `txstart` drops, and `synced`=0.
- A byte that arrives in HUNT while the history already matches is treated as byte 0 of SYNCED.

## Configuration
- `UART_LB_BRIDGE_TIMEOUT_EN` defined: the gap timer, `TIMEOUT` abort and `tocnt` are active.
- Undefined: no timer logic; a partial word waits indefinitely; `tocnt` is tied to 0.

## Structure
- Shared package `uart_lb_pkg` holds:
  - SYNC0, SYNC1.
  - Rx state enum {HUNT, SYNCED} and Tx state enum {IDLE, SEND, BUSY, DRAIN}.
  - Field widths CMDW=8, ADDRW=24, DATAW=32.
- One sub-module, `uart_lb_txser`: the Tx FSM and 64-bit shift register with the rdata/rready and txdata/txstart/txready ports.
- Rx hunting and assembly stay in the top module.

## Test plan
- Byte stream SYNC0, SYNC1, then 64'h0100001700e02281 → `synced`=1 after the 16th byte; one `wvalid` with `wcmd`=64'h0100001700e02281 one cycle after the 24th byte.
- 64'h0100001800000001 sent without sync → no `wvalid`, `synced`=0.
- Synced; SYNC0, SYNC1, then 64'h00000000facefeed → no pulses for the sync words; exactly one `wvalid` with `wcmd`=64'h00000000facefeed.
- With macro and TIMEOUT=50: 3 bytes, a 60-cycle gap, then sync + 64'h00000001deadbeef → `tocnt`=1 and `synced`=0 after the gap; then one `wvalid` with 64'h00000001deadbeef after re-sync.
- rvalid with `rdata`=64'hadbeef0012345678 and a UART model → `txdata` sequence ad, be, ef, 00, 12, 34, 56, 78; 8 `txstart` pulses; a second rvalid offered during transmission is held off (`rready`=0) until IDLE.
- `rstn` pulsed low after 5 bytes of a word → all outputs return to reset values; resending sync + word yields the correct `wcmd`.
